ssd1306_spi_rx: RTL



---
 rtl/ssd1306_spi_rx.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ssd1306_spi_rx.sv
// SSD1306-style 4-wire SPI display receiver: oversampled deserialiser, command decoder and framebuffer write port.
// Define SSD1306_RX_CHECK_EN to add the proto_err protocol-violation pulse output.
module ssd1306_spi_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              rst_btn,
  input  logic              ioSclk,
  input  logic              ioSdin,
  input  logic              ioCs,
  input  logic              ioDc,
  input  logic              ioReset,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_data,
  output logic              cmd_valid,
  output logic [7:0]        cmd_byte,
  output logic              display_on,
  output logic [7:0]        contrast,
  output logic              inverted,
  output logic [1:0]        addr_mode,
  output logic              charge_pump,
  output logic              frame_done,
  output logic              frag_err
`ifdef SSD1306_RX_CHECK_EN
  ,output logic             proto_err
`endif
);

  typedef enum logic {S_CMD = 1'b0, S_ARG = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] sclkSync, sdinSync, csSync, dcSync, resetSync;
  logic sclkPrev;
  logic sclkS, sdinS, csS, dcS, resetS;

  state_t            state;
  logic [7:0]        opcode;
  logic [6:0]        shiftReg;
  logic [2:0]        bitCnt;
  logic [ADDR_W-1:0] addr;

  logic       sclkRise, shiftEn;
  logic [7:0] byteNext;
  logic       isArgOp;
`ifdef SSD1306_RX_CHECK_EN
  logic       isListed;
  logic       lastDc;
`endif

  assign sclkS  = sclkSync[SYNC_STAGES-1];
  assign sdinS  = sdinSync[SYNC_STAGES-1];
  assign csS    = csSync[SYNC_STAGES-1];
  assign dcS    = dcSync[SYNC_STAGES-1];
  assign resetS = resetSync[SYNC_STAGES-1];

  // Idle-high lines reset high so release of rst_btn never looks like an sclk edge or a display reset.
  always_ff @(posedge clk or posedge rst_btn) begin
    if (rst_btn) begin
      sclkSync  <= '1;
      sdinSync  <= '0;
      csSync    <= '1;
      dcSync    <= '0;
      resetSync <= '1;
      sclkPrev  <= 1'b1;
    end else begin
      sclkSync  <= {sclkSync[SYNC_STAGES-2:0], ioSclk};
      sdinSync  <= {sdinSync[SYNC_STAGES-2:0], ioSdin};
      csSync    <= {csSync[SYNC_STAGES-2:0], ioCs};
      dcSync    <= {dcSync[SYNC_STAGES-2:0], ioDc};
      resetSync <= {resetSync[SYNC_STAGES-2:0], ioReset};
      sclkPrev  <= sclkS;
    end
  end

  always_comb begin
    sclkRise = sclkS & ~sclkPrev;
    shiftEn  = sclkRise & ~csS;
    byteNext = {shiftReg, sdinS};
    isArgOp  = byteNext inside {8'h81, 8'h20, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDB, 8'h8D};
`ifdef SSD1306_RX_CHECK_EN
    isListed = isArgOp || (byteNext[7:6] == 2'b01) ||
               (byteNext inside {8'hAE, 8'hAF, 8'hA4, 8'hA5, 8'hA6, 8'hA7,
                                 8'hC0, 8'hC8, 8'hA0, 8'hA1});
`endif
  end

  // rst_btn and a synchronised ioReset low restore the same state; the two branches must stay identical.
  always_ff @(posedge clk or posedge rst_btn) begin
    if (rst_btn) begin
      state <= S_CMD; opcode <= '0; shiftReg <= '0; bitCnt <= '0; addr <= '0;
      fb_we <= 1'b0; fb_addr <= '0; fb_data <= '0; cmd_valid <= 1'b0; cmd_byte <= '0;
      display_on <= 1'b0; contrast <= 8'h7F; inverted <= 1'b0; addr_mode <= '0;
      charge_pump <= 1'b0; frame_done <= 1'b0; frag_err <= 1'b0;
`ifdef SSD1306_RX_CHECK_EN
      proto_err <= 1'b0; lastDc <= 1'b0;
`endif
    end else if (!resetS) begin
      state <= S_CMD; opcode <= '0; shiftReg <= '0; bitCnt <= '0; addr <= '0;
      fb_we <= 1'b0; fb_addr <= '0; fb_data <= '0; cmd_valid <= 1'b0; cmd_byte <= '0;
      display_on <= 1'b0; contrast <= 8'h7F; inverted <= 1'b0; addr_mode <= '0;
      charge_pump <= 1'b0; frame_done <= 1'b0; frag_err <= 1'b0;
`ifdef SSD1306_RX_CHECK_EN
      proto_err <= 1'b0; lastDc <= 1'b0;
`endif
    end else begin
      fb_we      <= 1'b0;
      cmd_valid  <= 1'b0;
      frame_done <= 1'b0;
      frag_err   <= 1'b0;
`ifdef SSD1306_RX_CHECK_EN
      proto_err  <= 1'b0;
`endif
      if (csS) begin
        if (bitCnt != 3'd0) frag_err <= 1'b1;
        bitCnt <= '0;
      end else if (shiftEn) begin
        shiftReg <= byteNext[6:0];
        bitCnt   <= bitCnt + 3'd1;
`ifdef SSD1306_RX_CHECK_EN
        lastDc <= dcS;
        if (bitCnt != 3'd0 && dcS != lastDc) proto_err <= 1'b1;
`endif
        if (bitCnt == 3'd7) begin
          if (dcS) begin
            // Data bytes bypass the command FSM, so a pending argument survives them.
            fb_we      <= 1'b1;
            fb_data    <= byteNext;
            fb_addr    <= addr;
            addr       <= addr + ADDR_W'(1);
            frame_done <= &addr;
`ifdef SSD1306_RX_CHECK_EN
            if (!display_on || state == S_ARG) proto_err <= 1'b1;
`endif
          end else begin
            cmd_valid <= 1'b1;
            cmd_byte  <= byteNext;
            case (state)
              S_CMD: begin
                if (isArgOp) begin
                  opcode <= byteNext;
                  state  <= S_ARG;
                end else begin
                  case (byteNext)
                    8'hAE:   display_on <= 1'b0;
                    8'hAF:   display_on <= 1'b1;
                    8'hA6:   inverted   <= 1'b0;
                    8'hA7:   inverted   <= 1'b1;
                    default: ;
                  endcase
`ifdef SSD1306_RX_CHECK_EN
                  if (!isListed) proto_err <= 1'b1;
`endif
                end
              end
              S_ARG: begin
                case (opcode)
                  8'h81:   contrast    <= byteNext;
                  8'h20:   addr_mode   <= byteNext[1:0];
                  8'h8D:   charge_pump <= byteNext[2];
                  default: ;
                endcase
                state <= S_CMD;
              end
              default: state <= S_CMD;
            endcase
          end
        end
      end
    end
  end

endmodule
